// File: rtl/fpu_pkg.sv
// Shared types for the FP issue controller: FPU selector encodings, the
// sequencer state type, result-source select and default latencies.
package fpu_pkg;

  typedef enum logic [1:0] {
    KIND_BASIC   = 2'b00,
    KIND_FUSED   = 2'b01,
    KIND_CVT     = 2'b10,
    KIND_ILLEGAL = 2'b11
  } fpu_kind_t;

  // basic-op sub-selector (fpusel)
  typedef enum logic [3:0] {
    FPU_ADD   = 4'h0, FPU_SUB  = 4'h1, FPU_MUL  = 4'h2, FPU_DIV   = 4'h3,
    FPU_SQRT  = 4'h4, FPU_SGNJ = 4'h5, FPU_SGNJN = 4'h6, FPU_SGNJX = 4'h7,
    FPU_MIN   = 4'h8, FPU_MAX  = 4'h9, FPU_EQ   = 4'hA, FPU_LT    = 4'hB,
    FPU_LE    = 4'hC, FPU_CLASS = 4'hD, FPU_MVXW = 4'hE, FPU_MVWX = 4'hF
  } fpusel_t;

  // fused-op sub-selector (sd_sel)
  typedef enum logic [2:0] {
    SD_MADD = 3'd0, SD_MSUB = 3'd1, SD_NMSUB = 3'd2, SD_NMADD = 3'd3
  } sd_sel_t;

  // conversion sub-selector (cvtsel); the first two write the integer file
  typedef enum logic [2:0] {
    CVT_W_S = 3'd0, CVT_WU_S = 3'd1, CVT_S_W = 3'd2, CVT_S_WU = 3'd3
  } cvtsel_t;

  typedef enum logic [1:0] {IDLE, EXEC, ITER, WB} fpu_state_t;

  typedef enum logic [2:0] {
    SRC_RES, SRC_CMP, SRC_CVT, SRC_ITER, SRC_ZERO
  } res_src_t;

  localparam int DEF_ADD_LAT = 2;
  localparam int DEF_MUL_LAT = 3;
  localparam int DEF_FMA_LAT = 4;
  localparam int DEF_CVT_LAT = 2;

  function automatic int max_of(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // $clog2 of the largest latency, never narrower than one bit
  function automatic int cnt_width(input int max_lat);
    return (max_lat <= 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/fpu_lat_decode.sv
// Combinational class decode for an FP operation.
//   kind, op  : selector of the operation being issued
//   is_iter   : op runs on the iterative div/sqrt unit
//   lat_m1    : fixed latency minus one (counter load value)
//   wb_int    : result goes to the integer register file
//   src       : which FPU output is captured as the writeback result
module fpu_lat_decode
  import fpu_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int FMA_LAT = DEF_FMA_LAT,
  parameter int CVT_LAT = DEF_CVT_LAT,
  parameter int CNT_W   = 2
) (
  input  logic [1:0]       kind,
  input  logic [3:0]       op,
  output logic             is_iter,
  output logic [CNT_W-1:0] lat_m1,
  output logic             wb_int,
  output res_src_t         src
);

  localparam logic [CNT_W-1:0] ADD_M1 = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] FMA_M1 = CNT_W'(FMA_LAT - 1);
  localparam logic [CNT_W-1:0] CVT_M1 = CNT_W'(CVT_LAT - 1);

  always_comb begin
    is_iter = 1'b0;
    lat_m1  = '0;
    wb_int  = 1'b0;
    src     = SRC_RES;
    case (fpu_kind_t'(kind))
      KIND_BASIC: begin
        case (fpusel_t'(op))
          FPU_ADD, FPU_SUB: lat_m1 = ADD_M1;
          FPU_MUL:          lat_m1 = MUL_M1;
          FPU_DIV, FPU_SQRT: begin
            is_iter = 1'b1;
            src     = SRC_ITER;
          end
          FPU_EQ, FPU_LT, FPU_LE: begin
            src    = SRC_CMP;
            wb_int = 1'b1;
          end
          FPU_CLASS, FPU_MVXW: wb_int = 1'b1;
          default: ;
        endcase
      end
      KIND_FUSED: lat_m1 = FMA_M1;
      KIND_CVT: begin
        lat_m1 = CVT_M1;
        src    = SRC_CVT;
        wb_int = (op[2:0] == CVT_W_S) || (op[2:0] == CVT_WU_S);
      end
      default: src = SRC_ZERO;
    endcase
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Multi-cycle sequencer between EX and the RV32F datapath. Accepts one op,
// holds its selector/operands on the FPU inputs for the op's latency (or
// until the iterative unit finishes), then offers the result to writeback.
//   issue_*  : issue handshake and operation payload from EX
//   fpu_*    : latched selector/operands to the FPU, FPU results back
//   iter_*   : iterative div/sqrt start/kill/done/result
//   wb_*     : writeback handshake and payload
//   busy     : op in flight, used by the hazard unit; flush kills it
//
// state | meaning
// IDLE  | ready for a new op
// EXEC  | fixed-latency op, down-counter running
// ITER  | waiting on iterative div/sqrt
// WB    | result offered to writeback
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int FMA_LAT = DEF_FMA_LAT,
  parameter int CVT_LAT = DEF_CVT_LAT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [1:0]  issue_kind,
  input  logic [3:0]  issue_op,
  input  logic [4:0]  issue_rd,
  input  logic [31:0] issue_a,
  input  logic [31:0] issue_b,
  input  logic [31:0] issue_c,
  output logic [1:0]  fpu_kind,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  input  logic [31:0] fpu_res,
  input  logic [31:0] fpu_cvt_res,
  input  logic        fpu_cmp,
  output logic        iter_start,
  output logic        iter_kill,
  input  logic        iter_done,
  input  logic [31:0] iter_res,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_int,
  output logic        busy
);

  localparam int MAX_LAT = max_of(max_of(ADD_LAT, MUL_LAT), max_of(FMA_LAT, CVT_LAT));
  localparam int CNT_W   = cnt_width(MAX_LAT);

  fpu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [1:0]       kind_q, kind_d;
  logic [3:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  res_src_t         src_q, src_d;
  logic             int_q, int_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             wb_int_q, wb_int_d;

  logic             dec_is_iter, dec_wb_int, accept, capture;
  logic [CNT_W-1:0] dec_lat_m1;
  res_src_t         dec_src;

  fpu_lat_decode #(
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .FMA_LAT(FMA_LAT), .CVT_LAT(CVT_LAT),
    .CNT_W  (CNT_W)
  ) u_dec (
    .kind   (issue_kind),
    .op     (issue_op),
    .is_iter(dec_is_iter),
    .lat_m1 (dec_lat_m1),
    .wb_int (dec_wb_int),
    .src    (dec_src)
  );

  assign issue_ready = (state_q == IDLE) || ((state_q == WB) && wb_ready);
  // a flush always wins over an issue in the same cycle
  assign accept      = issue_valid && issue_ready && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    first_d   = 1'b0;
    kind_d    = kind_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    src_d     = src_q;
    int_d     = int_q;
    wb_data_d = wb_data_q;
    wb_int_d  = wb_int_q;
    capture   = 1'b0;

    if (accept) begin
      kind_d = issue_kind;
      op_d   = issue_op;
      rd_d   = issue_rd;
      a_d    = issue_a;
      b_d    = issue_b;
      c_d    = issue_c;
      src_d  = dec_src;
      int_d  = dec_wb_int;
    end

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        EXEC: begin
          if (cnt_q == '0) begin
            state_d = WB;
            capture = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ITER: begin
          // done is not trusted in the start cycle
          if (!first_q && iter_done) begin
            state_d = WB;
            capture = 1'b1;
          end
        end
        WB: begin
          if (wb_ready) state_d = IDLE;
        end
        default: ;
      endcase
      if (accept) begin
        state_d = dec_is_iter ? ITER : EXEC;
        cnt_d   = dec_is_iter ? '0 : dec_lat_m1;
        first_d = dec_is_iter;
      end
    end

    if (capture) begin
      wb_int_d = int_q;
      case (src_q)
        SRC_CMP:  wb_data_d = {31'b0, fpu_cmp};
        SRC_CVT:  wb_data_d = fpu_cvt_res;
        SRC_ITER: wb_data_d = iter_res;
        SRC_ZERO: wb_data_d = '0;
        default:  wb_data_d = fpu_res;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      first_q   <= 1'b0;
      kind_q    <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      src_q     <= SRC_RES;
      int_q     <= 1'b0;
      wb_data_q <= '0;
      wb_int_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      kind_q    <= kind_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      src_q     <= src_d;
      int_q     <= int_d;
      wb_data_q <= wb_data_d;
      wb_int_q  <= wb_int_d;
    end
  end

  assign fpu_kind   = kind_q;
  assign fpu_op     = op_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign fpu_c      = c_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = rd_q;
  assign wb_int     = wb_int_q;
  assign wb_valid   = (state_q == WB);
  assign busy       = (state_q != IDLE);
  assign iter_start = (state_q == ITER) && first_q;
  assign iter_kill  = (state_q == ITER) && flush;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

  localparam logic [31:0] ITER_VAL = 32'h3F00_0000;
  localparam logic [31:0] CVT_MASK = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush, issue_valid, issue_ready;
  logic [1:0]  issue_kind, fpu_kind;
  logic [3:0]  issue_op, fpu_op;
  logic [4:0]  issue_rd, wb_rd;
  logic [31:0] issue_a, issue_b, issue_c, fpu_a, fpu_b, fpu_c;
  logic [31:0] fpu_res, fpu_cvt_res, iter_res, wb_data;
  logic        fpu_cmp, iter_start, iter_kill, iter_done;
  logic        wb_valid, wb_ready, wb_int, busy;

  always #5 clk = ~clk;

  // FPU datapath stand-in: results derived from the latched operands
  assign fpu_res     = fpu_a + fpu_b;
  assign fpu_cvt_res = fpu_a ^ CVT_MASK;

  fpu_issue_ctrl #(.ADD_LAT(2), .MUL_LAT(3), .FMA_LAT(4), .CVT_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_kind(issue_kind), .issue_op(issue_op), .issue_rd(issue_rd),
    .issue_a(issue_a), .issue_b(issue_b), .issue_c(issue_c),
    .fpu_kind(fpu_kind), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c),
    .fpu_res(fpu_res), .fpu_cvt_res(fpu_cvt_res), .fpu_cmp(fpu_cmp),
    .iter_start(iter_start), .iter_kill(iter_kill), .iter_done(iter_done), .iter_res(iter_res),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .wb_int(wb_int), .busy(busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wint;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [1:0] tk  [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [3:0] top [9] = '{4'd0, 4'd11, 4'd2, 4'd5, 4'd13, 4'd0, 4'd0, 4'd2, 4'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_lat(input logic [1:0] k, input logic [3:0] op);
    case (k)
      2'd0:    return (op <= 4'd1) ? 2 : (op == 4'd2) ? 3 : 1;
      2'd1:    return 4;
      2'd2:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic exp_t model_wb(input logic [1:0] k, input logic [3:0] op,
                                    input logic [4:0] rd, input logic [31:0] a,
                                    input logic [31:0] b);
    exp_t e;
    e.rd   = rd;
    e.wint = 1'b0;
    e.data = a + b;
    case (k)
      2'd0: begin
        if (op >= 4'd10 && op <= 4'd12) e.data = 32'd1;   // fpu_cmp held at 1
        if (op == 4'd3 || op == 4'd4)   e.data = ITER_VAL;
        if (op >= 4'd10 && op <= 4'd14) e.wint = 1'b1;
      end
      2'd2: begin
        e.data = a ^ CVT_MASK;
        e.wint = (op[2:0] <= 3'd1);
      end
      2'd3: e.data = 32'd0;
      default: ;
    endcase
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic issue_drive(input logic [1:0] k, input logic [3:0] op, input logic [4:0] rd,
                             input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                             input bit push);
    issue_kind  = k;
    issue_op    = op;
    issue_rd    = rd;
    issue_a     = a;
    issue_b     = b;
    issue_c     = c;
    issue_valid = 1'b1;
    if (push) sb.push_back(model_wb(k, op, rd, a, b));
  endtask

  task automatic await_wb(input int max_cyc, output int n);
    n = 0;
    while (wb_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    chk({tag, "_sb_depth"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
      chk({tag, "_data"},  wb_data, e.data);
      chk({tag, "_rd"},    32'(wb_rd), 32'(e.rd));
      chk({tag, "_int"},   32'(wb_int), 32'(e.wint));
    end
  endtask

  task automatic run_fixed(input int i);
    int n;
    logic [31:0] a, b, c;
    a = 32'h3F80_0000 + 32'(i);
    b = 32'h4000_0000;
    c = 32'h1234_0000 + 32'(i);
    issue_drive(tk[i], top[i], 5'(i + 1), a, b, c, 1'b1);
    step();
    issue_valid = 1'b0;
    chk($sformatf("op%0d_fpu_a", i), fpu_a, a);
    chk($sformatf("op%0d_fpu_c", i), fpu_c, c);
    chk($sformatf("op%0d_fpu_kind", i), 32'(fpu_kind), 32'(tk[i]));
    chk($sformatf("op%0d_fpu_op", i), 32'(fpu_op), 32'(top[i]));
    await_wb(12, n);
    chk($sformatf("op%0d_latency", i), 32'(n), 32'(model_lat(tk[i], top[i])));
    check_wb($sformatf("op%0d_wb", i));
    step();
    chk($sformatf("op%0d_idle_busy", i), 32'(busy), 32'd0);
  endtask

  initial begin
    int n, starts, busy_low, wb_seen, kill_seen, busy_seen;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0;
    issue_kind = '0; issue_op = '0; issue_rd = '0;
    issue_a = '0; issue_b = '0; issue_c = '0;
    fpu_cmp = 1'b1; iter_done = 1'b0; iter_res = '0; wb_ready = 1'b1;

    #12;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_busy",        32'(busy), 32'd0);
    chk("rst_wb_valid",    32'(wb_valid), 32'd0);
    chk("rst_iter_start",  32'(iter_start), 32'd0);
    chk("rst_iter_kill",   32'(iter_kill), 32'd0);
    chk("rst_fpu_a",       fpu_a, 32'd0);
    chk("rst_wb_data",     wb_data, 32'd0);
    chk("rst_wb_int",      32'(wb_int), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // fixed-latency classes, writeback always ready
    for (int i = 0; i < 9; i++) run_fixed(i);

    // iterative divide, done 10 cycles after iter_start
    issue_drive(2'd0, 4'd3, 5'd9, 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b1);
    step();
    issue_valid = 1'b0;
    starts = 0; busy_low = 0;
    for (int i = 0; i < 10; i++) begin
      if (iter_start) starts++;
      if (!busy) busy_low++;
      step();
    end
    iter_done = 1'b1;
    iter_res  = ITER_VAL;
    step();
    iter_done = 1'b0;
    iter_res  = '0;
    chk("div_start_pulses", 32'(starts), 32'd1);
    chk("div_busy_low_cycles", 32'(busy_low), 32'd0);
    check_wb("div_wb");
    step();
    chk("div_idle_busy", 32'(busy), 32'd0);

    // writeback back-pressure with the next issue pending
    wb_ready = 1'b0;
    issue_drive(2'd0, 4'd2, 5'd12, 32'h0000_0010, 32'h0000_0020, 32'd0, 1'b1);
    step();
    issue_valid = 1'b0;
    await_wb(12, n);
    chk("bp_mul_latency", 32'(n), 32'd3);
    issue_drive(2'd0, 4'd1, 5'd13, 32'h0000_0100, 32'h0000_0200, 32'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_issue_ready", i), 32'(issue_ready), 32'd0);
      chk($sformatf("bp%0d_wb_valid", i), 32'(wb_valid), 32'd1);
      chk($sformatf("bp%0d_wb_data", i), wb_data, sb[0].data);
      chk($sformatf("bp%0d_wb_rd", i), 32'(wb_rd), 32'(sb[0].rd));
      step();
    end
    wb_ready = 1'b1;
    #1;
    chk("bp_issue_ready_release", 32'(issue_ready), 32'd1);
    check_wb("bp_mul_wb");
    step();
    issue_valid = 1'b0;
    chk("bp_next_wb_valid", 32'(wb_valid), 32'd0);
    chk("bp_next_busy", 32'(busy), 32'd1);
    chk("bp_next_fpu_op", 32'(fpu_op), 32'd1);
    chk("bp_next_fpu_a", fpu_a, 32'h0000_0100);
    await_wb(12, n);
    chk("bp_next_latency", 32'(n), 32'd2);
    check_wb("bp_sub_wb");
    step();

    // flush during ITER cycle 3, with an issue offered alongside
    issue_drive(2'd0, 4'd3, 5'd14, 32'd1, 32'd2, 32'd0, 1'b0);
    step();
    issue_valid = 1'b0;
    chk("fl_iter_start", 32'(iter_start), 32'd1);
    iter_done = 1'b1;
    iter_res  = 32'hDEAD_BEEF;
    step();
    iter_done = 1'b0;
    iter_res  = '0;
    chk("fl_done_ignored_wb_valid", 32'(wb_valid), 32'd0);
    chk("fl_done_ignored_busy", 32'(busy), 32'd1);
    step();
    flush = 1'b1;
    issue_drive(2'd0, 4'd0, 5'd15, 32'd5, 32'd6, 32'd0, 1'b0);
    #1;
    chk("fl_iter_kill", 32'(iter_kill), 32'd1);
    chk("fl_issue_ready", 32'(issue_ready), 32'd0);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    wb_seen = 0; kill_seen = 0; busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (wb_valid) wb_seen++;
      if (iter_kill) kill_seen++;
      if (busy) busy_seen++;
      step();
    end
    chk("fl_iter_wb_seen", 32'(wb_seen), 32'd0);
    chk("fl_iter_kill_after", 32'(kill_seen), 32'd0);
    chk("fl_iter_busy_after", 32'(busy_seen), 32'd0);

    // flush in IDLE drops a concurrent issue
    flush = 1'b1;
    issue_drive(2'd0, 4'd0, 5'd16, 32'd7, 32'd8, 32'd0, 1'b0);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("fl_idle_busy", 32'(busy), 32'd0);

    // flush during EXEC of a fused op
    issue_drive(2'd1, 4'd0, 5'd17, 32'd9, 32'd10, 32'd11, 1'b0);
    step();
    issue_valid = 1'b0;
    chk("fl_exec_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    wb_seen = 0; busy_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (wb_valid) wb_seen++;
      if (busy) busy_seen++;
      step();
    end
    chk("fl_exec_wb_seen", 32'(wb_seen), 32'd0);
    chk("fl_exec_busy_seen", 32'(busy_seen), 32'd0);

    // asynchronous reset in the middle of a fused op
    issue_drive(2'd1, 4'd1, 5'd18, 32'hAAAA_0000, 32'h5555, 32'h77, 1'b0);
    step();
    issue_valid = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstx_busy", 32'(busy), 32'd0);
    chk("rstx_wb_valid", 32'(wb_valid), 32'd0);
    chk("rstx_issue_ready", 32'(issue_ready), 32'd1);
    chk("rstx_fpu_a", fpu_a, 32'd0);
    chk("rstx_fpu_c", fpu_c, 32'd0);
    chk("rstx_fpu_kind", 32'(fpu_kind), 32'd0);
    chk("rstx_fpu_op", 32'(fpu_op), 32'd0);
    chk("rstx_wb_data", wb_data, 32'd0);
    chk("rstx_wb_rd", 32'(wb_rd), 32'd0);
    step();
    rst_n = 1'b1;
    wb_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (wb_valid) wb_seen++;
      step();
    end
    chk("rstx_wb_seen", 32'(wb_seen), 32'd0);
    chk("sb_empty_at_end", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
